// File: rtl/wave_capture_buffer_if.sv
// Sample-stream, trigger-control and frame-read bundle for the wave capture buffer.
// Acquisition logic sits on the slave side; the source and renderer use the master side.
interface wave_capture_buffer_if #(
    parameter int DW = 10,
    parameter int AW = 10
);
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [DW-1:0] trig_level;
    logic          arm;
    logic          single_shot;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          frame_ready;
    logic          auto_trig;
    logic          busy;

    modport master (
        output sample_in, sample_valid, trig_level, arm, single_shot, rd_addr,
        input  rd_data, frame_ready, auto_trig, busy
    );

    modport slave (
        input  sample_in, sample_valid, trig_level, arm, single_shot, rd_addr,
        output rd_data, frame_ready, auto_trig, busy
    );
endinterface

// File: rtl/wave_capture_buffer.sv
// Triggered circular capture of the sample stream. One DEPTH-sample frame, with
// PRE_TRIG samples of history before the trigger, is frozen and read out asynchronously.
module wave_capture_buffer #(
    parameter int DW           = 10,
    parameter int DEPTH        = 640,
    parameter int PRE_TRIG     = 160,
    parameter int AUTO_TIMEOUT = 4000,
    parameter int HOLD_SAMPLES = 2000
) (
    input  logic                  clk_20k,
    input  logic                  reset,
    wave_capture_buffer_if.slave  bus
);
    localparam int PW     = $clog2(DEPTH);
    localparam int IW     = PW + 2;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam int CM0    = (AUTO_TIMEOUT > HOLD_SAMPLES) ? AUTO_TIMEOUT : HOLD_SAMPLES;
    localparam int CMAX   = (CM0 > DEPTH) ? CM0 : DEPTH;
    localparam int CW     = $clog2(CMAX + 2);

    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POSTFILL, HOLD} state_t;

    state_t        r_state, w_state_nxt, w_start;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_wr_ptr, r_trig_ptr, w_trig_ptr_nxt;
    logic [DW-1:0] r_prev;
    logic          r_auto, w_auto_nxt;
    logic          w_wr, w_trig_hit;
    logic [IW-1:0] w_sum, w_idx;

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_20k or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_trig_ptr <= '0;
            r_prev     <= '0;
            r_auto     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_trig_ptr <= w_trig_ptr_nxt;
            r_auto     <= w_auto_nxt;
            if (bus.sample_valid)
                r_prev <= bus.sample_in;
            // Compare-and-wrap so non-power-of-two depths stay in range
            if (w_wr)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_20k) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= bus.sample_in;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_trig_ptr_nxt = r_trig_ptr;
        w_auto_nxt     = r_auto;
        w_wr           = 1'b0;
        w_start        = (PRE_TRIG == 0) ? WAIT_TRIG : PREFILL;
        w_trig_hit     = (r_prev < bus.trig_level) && (bus.sample_in >= bus.trig_level);
        if (bus.arm) begin
            // arm wins over any sample in the same cycle; that sample is dropped
            w_state_nxt = w_start;
            w_cnt_nxt   = '0;
            w_auto_nxt  = 1'b0;
        end else if (bus.sample_valid) begin
            unique case (r_state)
                IDLE: ;
                PREFILL: begin
                    w_wr = 1'b1;
                    if (r_cnt == CW'(PRE_TRIG - 1)) begin
                        w_state_nxt = WAIT_TRIG;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                WAIT_TRIG: begin
                    w_wr = 1'b1;
                    if (w_trig_hit || (AUTO_TIMEOUT != 0 && r_cnt == CW'(AUTO_TIMEOUT))) begin
                        w_trig_ptr_nxt = r_wr_ptr;
                        w_auto_nxt     = ~w_trig_hit;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = (POST_N == 0) ? HOLD : POSTFILL;
                    end else if (AUTO_TIMEOUT != 0) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                POSTFILL: begin
                    w_wr = 1'b1;
                    if (r_cnt == CW'(POST_N - 1)) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!bus.single_shot) begin
                        if (HOLD_SAMPLES <= 1 || r_cnt >= CW'(HOLD_SAMPLES - 1)) begin
                            w_state_nxt = w_start;
                            w_cnt_nxt   = '0;
                            w_auto_nxt  = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Oldest frame sample sits PRE_TRIG before the trigger, i.e. trig_ptr + DEPTH - PRE_TRIG
    always_comb begin
        w_sum = IW'(r_trig_ptr) + IW'(bus.rd_addr) + IW'(DEPTH - PRE_TRIG);
        if (w_sum >= IW'(2 * DEPTH))
            w_idx = w_sum - IW'(2 * DEPTH);
        else if (w_sum >= IW'(DEPTH))
            w_idx = w_sum - IW'(DEPTH);
        else
            w_idx = w_sum;
    end

    assign bus.rd_data     = (r_state == HOLD && IW'(bus.rd_addr) < IW'(DEPTH))
                             ? r_mem[w_idx[PW-1:0]] : '0;
    assign bus.frame_ready = (r_state == HOLD);
    assign bus.auto_trig   = (r_state == HOLD) && r_auto;
    assign bus.busy        = (r_state == PREFILL) || (r_state == WAIT_TRIG) || (r_state == POSTFILL);
endmodule

// File: tb/tb_wave_capture_buffer.sv
// Randomized bench for wave_capture_buffer; the reference keeps the written sample
// stream in a queue, so a held frame is simply the last DEPTH written samples.
module tb_wave_capture_buffer;
    localparam int DW = 10, DEPTH = 640, PRE = 160, AUTO = 4000, HOLDN = 2000;
    localparam int POST = DEPTH - PRE - 1;
    localparam int M_IDLE = 0, M_PRE = 1, M_WAIT = 2, M_POST = 3, M_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wave_capture_buffer_if #(.DW(DW), .AW(10)) bus ();

    wave_capture_buffer #(
        .DW(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE), .AUTO_TIMEOUT(AUTO), .HOLD_SAMPLES(HOLDN)
    ) dut (
        .clk_20k (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int checks = 0, failures = 0;
    int ph, n, prev, ramp, rd_a;
    bit auto_f, rnd_addr;
    int hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        ph = M_IDLE; n = 0; prev = 0; auto_f = 0;
        hist.delete();
    endtask

    // One clock of spec behaviour given the inputs present at the edge
    task automatic model_step(input bit v, input int s, input int tl, input bit a, input bit ss);
        if (a) begin
            ph = M_PRE; n = 0; auto_f = 0;
        end else if (v) begin
            if (ph == M_PRE || ph == M_WAIT || ph == M_POST) begin
                hist.push_back(s);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            case (ph)
                M_PRE: begin
                    n++;
                    if (n == PRE) begin ph = M_WAIT; n = 0; end
                end
                M_WAIT: begin
                    if (prev < tl && s >= tl) begin ph = M_POST; n = 0; auto_f = 0; end
                    else if (n == AUTO) begin ph = M_POST; n = 0; auto_f = 1; end
                    else n++;
                end
                M_POST: begin
                    n++;
                    if (n == POST) begin ph = M_HOLD; n = 0; end
                end
                M_HOLD: begin
                    if (!ss) begin
                        n++;
                        if (n == HOLDN) begin ph = M_PRE; n = 0; auto_f = 0; end
                    end
                end
                default: ;
            endcase
        end
        if (v) prev = s;
    endtask

    function automatic int exp_rd(input int a);
        if (ph != M_HOLD || a >= DEPTH || hist.size() < DEPTH) return 0;
        return hist[hist.size() - DEPTH + a];
    endfunction

    task automatic check_all();
        chk("frame_ready", bus.frame_ready, ph == M_HOLD);
        chk("busy", bus.busy, ph == M_PRE || ph == M_WAIT || ph == M_POST);
        chk("auto_trig", bus.auto_trig, ph == M_HOLD && auto_f);
        chk("rd_data", bus.rd_data, exp_rd(int'(bus.rd_addr)));
    endtask

    task automatic cyc(input bit v, input int s, input bit a);
        bus.sample_valid = v;
        bus.sample_in    = DW'(s);
        bus.arm          = a;
        bus.rd_addr      = rnd_addr ? 10'($urandom_range(0, 1023)) : 10'(rd_a);
        @(posedge clk);
        model_step(v, s, int'(bus.trig_level), a, bus.single_shot);
        #1;
        check_all();
    endtask

    // kind: 0 ramp, 1 const 100, 2 random; vmode: 0 always, 1 one-in-three, 2 random
    // stop: 0 never, 1 at HOLD, 2 on leaving HOLD, 3 at POSTFILL
    task automatic feed(input int kind, input int vmode, input int ncyc, input int stop, output int nv);
        nv = 0;
        for (int i = 0; i < ncyc; i++) begin
            bit v;
            int s;
            if (stop == 1 && ph == M_HOLD) break;
            if (stop == 2 && ph != M_HOLD) break;
            if (stop == 3 && ph == M_POST) break;
            case (vmode)
                0: v = 1'b1;
                1: v = (i % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s = (kind == 0) ? ramp : (kind == 1) ? 100 : int'($urandom_range(0, 1023));
            if (v && kind == 0) ramp = (ramp + 1) % DEPTH;
            if (v) nv++;
            cyc(v, s, 1'b0);
        end
    endtask

    task automatic rd_chk(input string tag, input int a, input int exp);
        rnd_addr = 1'b0;
        rd_a = a;
        cyc(1'b0, 0, 1'b0);
        chk(tag, bus.rd_data, exp);
        rnd_addr = 1'b1;
    endtask

    task automatic ramp_frame_checks(input string pfx);
        rd_chk({pfx, "_rd0"}, 0, 160);
        rd_chk({pfx, "_rd160"}, 160, 320);
        rd_chk({pfx, "_rd479"}, 479, 639);
        rd_chk({pfx, "_rd480"}, 480, 0);
        rd_chk({pfx, "_rd639"}, 639, 159);
        rd_chk({pfx, "_rd700"}, 700, 0);
        chk({pfx, "_auto"}, bus.auto_trig, 0);
    endtask

    task automatic do_reset();
        bus.sample_valid = 1'b0;
        bus.arm = 1'b0;
        #2 rst = 1'b1;
        #1;
        mreset();
        chk("rst_frame_ready", bus.frame_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int nv;
        rst = 1'b1;
        bus.sample_in = '0; bus.sample_valid = 1'b0; bus.trig_level = 10'd320;
        bus.arm = 1'b0; bus.single_shot = 1'b1; bus.rd_addr = '0;
        rnd_addr = 1'b1; rd_a = 0; ramp = 0;
        mreset();
        #12;
        chk("reset_frame_ready", bus.frame_ready, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_auto", bus.auto_trig, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        rst = 1'b0;

        // Ramp, single shot: trigger on 320, frame 160..639,0..159
        feed(2, 2, 20, 0, nv);
        ramp = 0;
        cyc(1'b0, 0, 1'b1);
        feed(0, 0, 2000, 1, nv);
        chk("c1_ready", bus.frame_ready, 1);
        chk("c1_samples", nv, PRE + 161 + POST);
        ramp_frame_checks("c1");
        feed(0, 0, 10000, 0, nv);
        chk("c1_still_ready", bus.frame_ready, 1);
        cyc(1'b0, 0, 1'b1);
        chk("c1_arm_drop", bus.frame_ready, 0);

        // Same ramp with one-in-three valid
        ramp = 0;
        cyc(1'b0, 0, 1'b1);
        feed(0, 1, 6000, 1, nv);
        chk("c6_ready", bus.frame_ready, 1);
        ramp_frame_checks("c6");

        // Constant input forces an auto trigger on the 4001st waiting sample
        cyc(1'b0, 0, 1'b1);
        feed(1, 0, 6000, 1, nv);
        chk("c2_ready", bus.frame_ready, 1);
        chk("c2_samples", nv, PRE + AUTO + 1 + POST);
        chk("c2_auto", bus.auto_trig, 1);
        for (int a = 0; a < DEPTH; a++) rd_chk("c2_all100", a, 100);

        // Continuous mode: hold for 2000 samples then re-acquire
        bus.single_shot = 1'b0;
        ramp = 0;
        cyc(1'b0, 0, 1'b1);
        feed(0, 0, 2000, 1, nv);
        rd_chk("c3_rd160_a", 160, 320);
        feed(0, 0, 3000, 2, nv);
        chk("c3_hold_len", nv, HOLDN);
        chk("c3_busy", bus.busy, 1);
        chk("c3_ready_drop", bus.frame_ready, 0);
        feed(0, 0, 3000, 1, nv);
        chk("c3_ready_b", bus.frame_ready, 1);
        rd_chk("c3_rd160_b", 160, 320);
        bus.single_shot = 1'b1;

        // Re-arm in WAIT_TRIG; the 310->330 crossing lands in the new PREFILL
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < PRE + 5; i++) cyc(1'b1, 0, 1'b0);
        chk("c4_waiting", bus.busy, 1);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 310, 1'b0);
        cyc(1'b1, 330, 1'b0);
        for (int i = 0; i < PRE - 2; i++) cyc(1'b1, int'($urandom_range(0, 319)), 1'b0);
        chk("c4_no_ready", bus.frame_ready, 0);
        chk("c4_rd_zero", bus.rd_data, 0);

        // Reset during POSTFILL, idle samples, then reset out of HOLD
        ramp = 0;
        cyc(1'b0, 0, 1'b1);
        feed(0, 0, 2000, 3, nv);
        feed(0, 0, 20, 0, nv);
        do_reset();
        feed(2, 0, 100, 0, nv);
        chk("c5_idle", bus.busy, 0);
        ramp = 0;
        cyc(1'b0, 0, 1'b1);
        feed(0, 0, 2000, 1, nv);
        ramp_frame_checks("c5");
        do_reset();

        // Random traffic
        for (int blk = 0; blk < 40; blk++) begin
            bus.trig_level  = 10'($urandom_range(0, 1023));
            bus.single_shot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), 1'b1);
            feed(2, 2, 500, 0, nv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
